// File: rtl/sincronizador_comas_pkg.sv
// Shared constants, state encoding and helpers for the word-synchronisation stage
// and the 8b/10b blocks that reuse its classifier.
package sincronizador_comas_pkg;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        PERDIDA  = 2'b00,
        ADQ      = 2'b01,
        SINC     = 2'b10,
        SINC_ERR = 2'b11
    } estado_t;

    localparam int COMAS_ADQ_DEF  = 3;
    localparam int ERR_MAX_DEF    = 4;
    localparam int BUENAS_REC_DEF = 4;

    // Number of ones in a 10-bit code group; balanced groups carry 4, 5 or 6.
    function automatic logic [3:0] popcount10(input logic [9:0] palabra);
        logic [3:0] suma;
        suma = 4'd0;
        for (int i = 0; i < 10; i++) begin
            suma = suma + {3'b000, palabra[i]};
        end
        return suma;
    endfunction

endpackage

// File: rtl/sincronizador_comas_if.sv
// Word stream into the synchroniser and tagged word stream out of it.
interface sincronizador_comas_if;

    logic       enb;
    logic       valida;
    logic [9:0] entradas;
    logic [9:0] salidas;
    logic       valida_sal;
    logic       es_coma;
    logic       sincronizado;
    logic [7:0] errores;

    modport slave (
        input  enb, valida, entradas,
        output salidas, valida_sal, es_coma, sincronizado, errores
    );

    modport master (
        output enb, valida, entradas,
        input  salidas, valida_sal, es_coma, sincronizado, errores
    );

endinterface

// File: rtl/sincronizador_comas_clasificador_palabra.sv
// Combinational code-group classifier: K28.5 detection and running-disparity
// sanity check by popcount.
module clasificador_palabra
    import sincronizador_comas_pkg::*;
(
    input  logic [9:0] palabra,
    output logic       es_coma,
    output logic       es_mala
);

    logic [3:0] unos_s;

    // A comma is balanced by construction, so it can never be flagged bad.
    always_comb begin
        unos_s  = popcount10(palabra);
        es_coma = (palabra == K28_5_RDN) || (palabra == K28_5_RDP);
        if ((unos_s >= 4'd4) && (unos_s <= 4'd6)) begin
            es_mala = 1'b0;
        end else begin
            es_mala = !es_coma;
        end
    end

endmodule

// File: rtl/sincronizador_comas.sv
// Word synchroniser: forwards every accepted code group, tracks comma-based
// acquisition and error-based loss of sync, and counts bad words while synced.
module sincronizador_comas
    import sincronizador_comas_pkg::*;
#(
    parameter int COMAS_ADQ  = COMAS_ADQ_DEF,
    parameter int ERR_MAX    = ERR_MAX_DEF,
    parameter int BUENAS_REC = BUENAS_REC_DEF
)(
    input  logic                 clk,
    input  logic                 rst,
    sincronizador_comas_if.slave bus
);

    localparam int W_COMA   = $clog2(COMAS_ADQ + 1);
    localparam int W_ERR    = $clog2(ERR_MAX + 1);
    localparam int W_BUENAS = $clog2(BUENAS_REC + 1);

    localparam logic [W_COMA-1:0]   COMA_CERO   = W_COMA'(0);
    localparam logic [W_COMA-1:0]   COMA_UNO    = W_COMA'(1);
    localparam logic [W_COMA-1:0]   COMA_FIN    = W_COMA'(COMAS_ADQ);
    localparam logic [W_ERR-1:0]    ERR_CERO    = W_ERR'(0);
    localparam logic [W_ERR-1:0]    ERR_UNO     = W_ERR'(1);
    localparam logic [W_ERR-1:0]    ERR_FIN     = W_ERR'(ERR_MAX);
    localparam logic [W_BUENAS-1:0] BUENAS_CERO = W_BUENAS'(0);
    localparam logic [W_BUENAS-1:0] BUENAS_UNO  = W_BUENAS'(1);
    localparam logic [W_BUENAS-1:0] BUENAS_FIN  = W_BUENAS'(BUENAS_REC);

    estado_t             estado_r;
    logic [W_COMA-1:0]   cnt_coma_r;
    logic [W_ERR-1:0]    cnt_err_r;
    logic [W_BUENAS-1:0] cnt_buenas_r;
    logic [9:0]          salidas_r;
    logic                valida_sal_r;
    logic                es_coma_r;
    logic                sincronizado_r;
    logic [7:0]          errores_r;

    logic                coma_s;
    logic                mala_s;
    logic [W_COMA-1:0]   coma_sig_s;
    logic [W_ERR-1:0]    err_sig_s;
    logic [W_BUENAS-1:0] buenas_sig_s;
    logic [7:0]          errores_sig_s;

    clasificador_palabra u_clasificador (
        .palabra (bus.entradas),
        .es_coma (coma_s),
        .es_mala (mala_s)
    );

    assign coma_sig_s    = cnt_coma_r + COMA_UNO;
    assign err_sig_s     = cnt_err_r + ERR_UNO;
    assign buenas_sig_s  = cnt_buenas_r + BUENAS_UNO;
    assign errores_sig_s = (errores_r == 8'hFF) ? 8'hFF : (errores_r + 8'd1);

    assign bus.salidas      = salidas_r;
    assign bus.valida_sal   = valida_sal_r;
    assign bus.es_coma      = es_coma_r;
    assign bus.sincronizado = sincronizado_r;
    assign bus.errores      = errores_r;

    // Sync FSM, counters and forwarded word; enb=0 freezes everything, valida_sal included.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r       <= PERDIDA;
            cnt_coma_r     <= COMA_CERO;
            cnt_err_r      <= ERR_CERO;
            cnt_buenas_r   <= BUENAS_CERO;
            salidas_r      <= 10'd0;
            valida_sal_r   <= 1'b0;
            es_coma_r      <= 1'b0;
            sincronizado_r <= 1'b0;
            errores_r      <= 8'd0;
        end else if (bus.enb) begin
            valida_sal_r <= bus.valida;
            if (bus.valida) begin
                salidas_r <= bus.entradas;
                es_coma_r <= coma_s;
                case (estado_r)
                    PERDIDA, ADQ: begin
                        if (coma_s) begin
                            if (coma_sig_s == COMA_FIN) begin
                                estado_r       <= SINC;
                                sincronizado_r <= 1'b1;
                                cnt_coma_r     <= COMA_CERO;
                                cnt_err_r      <= ERR_CERO;
                                cnt_buenas_r   <= BUENAS_CERO;
                            end else begin
                                estado_r   <= ADQ;
                                cnt_coma_r <= coma_sig_s;
                            end
                        end else if (mala_s) begin
                            estado_r   <= PERDIDA;
                            cnt_coma_r <= COMA_CERO;
                        end
                    end
                    SINC, SINC_ERR: begin
                        if (mala_s) begin
                            errores_r    <= errores_sig_s;
                            cnt_buenas_r <= BUENAS_CERO;
                            if (err_sig_s == ERR_FIN) begin
                                estado_r       <= PERDIDA;
                                sincronizado_r <= 1'b0;
                                cnt_err_r      <= ERR_CERO;
                                cnt_coma_r     <= COMA_CERO;
                            end else begin
                                estado_r  <= SINC_ERR;
                                cnt_err_r <= err_sig_s;
                            end
                        end else if (estado_r == SINC_ERR) begin
                            // Errors are forgiven only after an unbroken run of good words.
                            if (buenas_sig_s == BUENAS_FIN) begin
                                estado_r     <= SINC;
                                cnt_err_r    <= ERR_CERO;
                                cnt_buenas_r <= BUENAS_CERO;
                            end else begin
                                cnt_buenas_r <= buenas_sig_s;
                            end
                        end
                    end
                    default: begin
                        estado_r       <= PERDIDA;
                        sincronizado_r <= 1'b0;
                        cnt_coma_r     <= COMA_CERO;
                        cnt_err_r      <= ERR_CERO;
                        cnt_buenas_r   <= BUENAS_CERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sincronizador_comas.sv
// Directed bench for sincronizador_comas: a vector table for the main protocol
// walk, plus hand-written sequences for enable hold and error saturation.
module tb_sincronizador_comas;

    localparam logic [9:0] C  = 10'b0011111010;
    localparam logic [9:0] CP = 10'b1100000101;
    localparam logic [9:0] G  = 10'b1011001100;
    localparam logic [9:0] B  = 10'b0000000011;
    localparam logic [9:0] B7 = 10'b1111111000;

    typedef struct {
        logic       rst;
        logic       enb;
        logic       valida;
        logic [9:0] din;
        logic [9:0] sal;
        logic       vs;
        logic       ec;
        logic       sinc;
        logic [7:0] err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_comp;
    int   n_fail;
    vec_t tabla[$];

    sincronizador_comas_if bus();

    sincronizador_comas dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic e, input logic va, input logic [9:0] d,
                               input logic [9:0] s, input logic vs, input logic ec,
                               input logic si, input logic [7:0] er);
        vec_t x;
        x.rst = r; x.enb = e; x.valida = va; x.din = d;
        x.sal = s; x.vs = vs; x.ec = ec; x.sinc = si; x.err = er;
        return x;
    endfunction

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        n_comp++;
        if (actual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nombre, actual, esperado);
        end
    endtask

    task automatic paso(input logic r, input logic e, input logic va, input logic [9:0] d);
        rst          = r;
        bus.enb      = e;
        bus.valida   = va;
        bus.entradas = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_todo(input string et, input logic [9:0] s, input logic vs,
                            input logic ec, input logic si, input logic [7:0] er);
        chk({et, ".salidas"},      {22'd0, bus.salidas},      {22'd0, s});
        chk({et, ".valida_sal"},   {31'd0, bus.valida_sal},   {31'd0, vs});
        chk({et, ".es_coma"},      {31'd0, bus.es_coma},      {31'd0, ec});
        chk({et, ".sincronizado"}, {31'd0, bus.sincronizado}, {31'd0, si});
        chk({et, ".errores"},      {24'd0, bus.errores},      {24'd0, er});
    endtask

    initial begin
        int n_malas;
        n_comp = 0;
        n_fail = 0;

        // rst, enb, valida, din | salidas, valida_sal, es_coma, sincronizado, errores
        tabla.push_back(v(1'b1, 1'b1, 1'b1, C,  10'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        tabla.push_back(v(1'b0, 1'b1, 1'b0, G,  10'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, C,  C,     1'b1, 1'b1, 1'b0, 8'd0));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, C,  C,     1'b1, 1'b1, 1'b0, 8'd0));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, CP, CP,    1'b1, 1'b1, 1'b1, 8'd0));
        tabla.push_back(v(1'b0, 1'b1, 1'b0, G,  CP,    1'b0, 1'b1, 1'b1, 8'd0));
        // one bad word, then four good ones restore SINC
        tabla.push_back(v(1'b0, 1'b1, 1'b1, B,  B,     1'b1, 1'b0, 1'b1, 8'd1));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, G,  G,     1'b1, 1'b0, 1'b1, 8'd1));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, G,  G,     1'b1, 1'b0, 1'b1, 8'd1));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, G,  G,     1'b1, 1'b0, 1'b1, 8'd1));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, G,  G,     1'b1, 1'b0, 1'b1, 8'd1));
        // four bad words split by single good ones: loss on the fourth
        tabla.push_back(v(1'b0, 1'b1, 1'b1, B,  B,     1'b1, 1'b0, 1'b1, 8'd2));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, G,  G,     1'b1, 1'b0, 1'b1, 8'd2));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, B,  B,     1'b1, 1'b0, 1'b1, 8'd3));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, G,  G,     1'b1, 1'b0, 1'b1, 8'd3));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, B,  B,     1'b1, 1'b0, 1'b1, 8'd4));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, G,  G,     1'b1, 1'b0, 1'b1, 8'd4));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, B,  B,     1'b1, 1'b0, 1'b0, 8'd5));
        // interrupted acquisition restarts the comma count
        tabla.push_back(v(1'b0, 1'b1, 1'b1, C,  C,     1'b1, 1'b1, 1'b0, 8'd5));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, C,  C,     1'b1, 1'b1, 1'b0, 8'd5));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, B7, B7,    1'b1, 1'b0, 1'b0, 8'd5));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, C,  C,     1'b1, 1'b1, 1'b0, 8'd5));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, C,  C,     1'b1, 1'b1, 1'b0, 8'd5));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, G,  G,     1'b1, 1'b0, 1'b0, 8'd5));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, CP, CP,    1'b1, 1'b1, 1'b1, 8'd5));
        // reset during SINC_ERR with a word on the same edge
        tabla.push_back(v(1'b0, 1'b1, 1'b1, B,  B,     1'b1, 1'b0, 1'b1, 8'd6));
        tabla.push_back(v(1'b1, 1'b1, 1'b1, C,  10'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        tabla.push_back(v(1'b0, 1'b1, 1'b0, C,  10'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        tabla.push_back(v(1'b0, 1'b1, 1'b1, C,  C,     1'b1, 1'b1, 1'b0, 8'd0));

        for (int i = 0; i < tabla.size(); i++) begin
            paso(tabla[i].rst, tabla[i].enb, tabla[i].valida, tabla[i].din);
            chk_todo($sformatf("vec%0d", i), tabla[i].sal, tabla[i].vs,
                     tabla[i].ec, tabla[i].sinc, tabla[i].err);
        end

        // Disabled: commas strobed in must leave every output (valida_sal too) frozen.
        for (int i = 0; i < 5; i++) begin
            paso(1'b0, 1'b0, 1'b1, CP);
            chk_todo($sformatf("enb0_%0d", i), C, 1'b1, 1'b1, 1'b0, 8'd0);
        end
        paso(1'b0, 1'b1, 1'b0, CP);
        chk_todo("reenb_idle", C, 1'b0, 1'b1, 1'b0, 8'd0);
        paso(1'b0, 1'b1, 1'b1, CP);
        chk_todo("reenb_coma2", CP, 1'b1, 1'b1, 1'b0, 8'd0);
        paso(1'b0, 1'b1, 1'b1, C);
        chk_todo("reenb_coma3", C, 1'b1, 1'b1, 1'b1, 8'd0);

        // 300 bad words while synced, re-acquiring after each loss.
        n_malas = 0;
        for (int blq = 0; blq < 75; blq++) begin
            for (int k = 0; k < 3; k++) begin
                paso(1'b0, 1'b1, 1'b1, C);
            end
            chk($sformatf("sat_sinc%0d", blq), {31'd0, bus.sincronizado}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                paso(1'b0, 1'b1, 1'b1, B);
                n_malas++;
                chk($sformatf("sat_err%0d", n_malas), {24'd0, bus.errores},
                    (n_malas > 255) ? 32'd255 : n_malas);
            end
            chk($sformatf("sat_loss%0d", blq), {31'd0, bus.sincronizado}, 32'd0);
        end
        paso(1'b0, 1'b1, 1'b0, G);
        chk("sat_final", {24'd0, bus.errores}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
        $finish;
    end

endmodule
